// File: rtl/pe2ddr_wr_cmd_gen_pkg.sv
// pe2ddr_wr_cmd_gen_pkg: shared widths, bit-width helper and the write command type
package pe2ddr_wr_cmd_gen_pkg;
   localparam int DDR_ADDR_W = 32;
   localparam int BURST_W    = 16;

   function automatic int bw(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   typedef struct packed {
      logic [DDR_ADDR_W-1:0] addr;
      logic [BURST_W-1:0]    bytes;
   } wr_cmd_t;
endpackage

// File: rtl/pe2ddr_outstanding_cnt.sv
// pe2ddr_outstanding_cnt: up/down count of issued-but-unanswered commands
module pe2ddr_outstanding_cnt #(
   parameter int MAX = 8,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         full,
   output logic         empty,
   output logic         underflow
);
   assign full      = cnt >= W'(MAX);
   assign empty     = cnt == '0;
   assign underflow = dec & ~inc & empty;

   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (inc & ~dec) cnt <= cnt + 1'b1;
      else if (dec & ~inc & ~empty) cnt <= cnt - 1'b1;
endmodule

// File: rtl/pe2ddr_wr_cmd_gen.sv
// pe2ddr_wr_cmd_gen: expands a row/burst job into DDR write commands of at most
// MAX_CMD_BYTES each and reports done once every command has been answered
module pe2ddr_wr_cmd_gen
   import pe2ddr_wr_cmd_gen_pkg::*;
#(
   parameter int MAX_CMD_BYTES   = 256,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  done,
   input  logic [DDR_ADDR_W-1:0] st_addr,
   input  logic [BURST_W-1:0]    burst,
   input  logic [DDR_ADDR_W-1:0] step,
   input  logic [BURST_W-1:0]    burst_num,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [DDR_ADDR_W-1:0] cmd_addr,
   output logic [BURST_W-1:0]    cmd_bytes,
   input  logic                  resp_valid,
   output logic                  resp_err
);
   localparam int OW = bw(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {WCG_IDLE, WCG_ISSUE, WCG_DRAIN} state_t;

   state_t                state, state_nxt;
   logic [BURST_W-1:0]    cfg_burst, cfg_num, row_cnt, offset, remaining;
   logic [DDR_ADDR_W-1:0] cfg_step, row_base;
   logic [OW-1:0]         out_cnt;
   logic                  full, empty, underflow, go, hs, last_seg, row_last;
   wr_cmd_t               cmd;

   assign go        = (state == WCG_IDLE) && start;
   assign remaining = cfg_burst - offset;
   assign cmd       = '{addr:  row_base + DDR_ADDR_W'(offset),
                        bytes: (remaining > BURST_W'(MAX_CMD_BYTES)) ? BURST_W'(MAX_CMD_BYTES) : remaining};
   assign last_seg  = remaining == cmd.bytes;
   assign row_last  = row_cnt == cfg_num;
   assign cmd_valid = (state == WCG_ISSUE) && !full;
   assign hs        = cmd_valid && cmd_ready;
   assign cmd_addr  = (state == WCG_ISSUE) ? cmd.addr : '0;
   assign cmd_bytes = (state == WCG_ISSUE) ? cmd.bytes : '0;
   assign done      = state == WCG_IDLE;

   pe2ddr_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(OW)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (hs),
      .dec       (resp_valid),
      .cnt       (out_cnt),
      .full      (full),
      .empty     (empty),
      .underflow (underflow)
   );

   always_comb begin
      state_nxt = state;
      if (go) state_nxt = (burst == '0) ? WCG_DRAIN : WCG_ISSUE;
      else if (state == WCG_ISSUE && hs && last_seg && row_last) state_nxt = WCG_DRAIN;
      else if (state == WCG_DRAIN && empty && !resp_valid) state_nxt = WCG_IDLE;
   end

   always_ff @(posedge clk)
      if (rst) state <= WCG_IDLE;
      else state <= state_nxt;

   // Row/offset sequencing only advances on a handshake, keeping the command stable while stalled
   always_ff @(posedge clk)
      if (rst) begin
         cfg_burst <= '0;
         cfg_num   <= '0;
         cfg_step  <= '0;
         row_base  <= '0;
         row_cnt   <= '0;
         offset    <= '0;
      end else if (go) begin
         cfg_burst <= burst;
         cfg_num   <= burst_num;
         cfg_step  <= step;
         row_base  <= st_addr;
         row_cnt   <= '0;
         offset    <= '0;
      end else if (hs) begin
         if (!last_seg) offset <= offset + cmd.bytes;
         else if (!row_last) begin
            row_cnt  <= row_cnt + 1'b1;
            row_base <= row_base + cfg_step;
            offset   <= '0;
         end
      end

   always_ff @(posedge clk)
      if (rst) resp_err <= 1'b0;
      else resp_err <= underflow | (resp_err & ~go);
endmodule

// File: tb/tb_pe2ddr_wr_cmd_gen.sv
// tb_pe2ddr_wr_cmd_gen: directed jobs against hand-computed command streams and done timing
module tb_pe2ddr_wr_cmd_gen;
   logic        clk, rst, start, done, cmd_valid, cmd_ready, resp_valid, resp_err;
   logic [31:0] st_addr, step, cmd_addr;
   logic [15:0] burst, burst_num, cmd_bytes;

   logic [31:0] qa[$];
   logic [15:0] qb[$];
   int          vectors, miscompares, resp_budget, n;
   bit          auto_resp, rdy;

   pe2ddr_wr_cmd_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .done       (done),
      .st_addr    (st_addr),
      .burst      (burst),
      .step       (step),
      .burst_num  (burst_num),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_bytes  (cmd_bytes),
      .resp_valid (resp_valid),
      .resp_err   (resp_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, record a handshake that the next posedge will take
   task automatic tick();
      resp_valid = resp_budget > 0;
      if (resp_valid) resp_budget--;
      cmd_ready = rdy;
      #1;
      if (cmd_valid && cmd_ready && !rst) begin
         qa.push_back(cmd_addr);
         qb.push_back(cmd_bytes);
         if (auto_resp) resp_budget++;
      end
      @(negedge clk);
   endtask

   task automatic job(input logic [31:0] a, input logic [15:0] b, input logic [31:0] s, input logic [15:0] num);
      st_addr = a; burst = b; step = s; burst_num = num;
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      while (!done && cyc < max) begin
         tick();
         cyc++;
      end
      chk("done_reached", done, 1);
   endtask

   task automatic chk_cmd(input string tag, input int i, input logic [31:0] a, input logic [15:0] b);
      chk({tag, "_addr"}, (i < qa.size()) ? qa[i] : 32'hDEAD_BEEF, a);
      chk({tag, "_bytes"}, (i < qb.size()) ? qb[i] : 16'hDEAD, b);
   endtask

   initial begin
      vectors = 0; miscompares = 0; resp_budget = 0; auto_resp = 0; rdy = 0;
      rst = 1; start = 0; st_addr = 0; burst = 0; step = 0; burst_num = 0;
      cmd_ready = 0; resp_valid = 0;
      @(negedge clk);
      tick(); tick();
      chk("rst_done", done, 1);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_addr", cmd_addr, 0);
      chk("rst_bytes", cmd_bytes, 0);
      chk("rst_err", resp_err, 0);
      rst = 0;

      // three rows of 96 bytes, immediate responses
      auto_resp = 1; rdy = 1;
      job(32'h1000, 16'd96, 32'h400, 16'd2);
      chk("t1_done_low", done, 0);
      wait_done(50, n);
      chk("t1_latency", n, 5);
      chk("t1_count", qa.size(), 3);
      chk_cmd("t1_c0", 0, 32'h1000, 16'd96);
      chk_cmd("t1_c1", 1, 32'h1400, 16'd96);
      chk_cmd("t1_c2", 2, 32'h1800, 16'd96);

      // one 600-byte row split at 256, address wraps past 2^32
      qa.delete(); qb.delete();
      job(32'hFFFF_FF80, 16'd600, 32'h0, 16'd0);
      wait_done(50, n);
      chk("t2_count", qa.size(), 3);
      chk_cmd("t2_c0", 0, 32'hFFFF_FF80, 16'd256);
      chk_cmd("t2_c1", 1, 32'h0000_0080, 16'd256);
      chk_cmd("t2_c2", 2, 32'h0000_0180, 16'd88);

      // ready stall for 5 cycles after the first command
      qa.delete(); qb.delete();
      job(32'h3000, 16'd512, 32'h1000, 16'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         rdy = 0;
         tick();
         chk("t3_stall_valid", cmd_valid, 1);
         chk("t3_stall_addr", cmd_addr, 32'h3100);
         chk("t3_stall_bytes", cmd_bytes, 16'd256);
      end
      rdy = 1;
      wait_done(50, n);
      chk("t3_count", qa.size(), 4);
      chk_cmd("t3_c1", 1, 32'h3100, 16'd256);
      chk_cmd("t3_c2", 2, 32'h4000, 16'd256);
      chk_cmd("t3_c3", 3, 32'h4100, 16'd256);

      // responses withheld: stops at 8 outstanding, one response frees one slot
      qa.delete(); qb.delete();
      auto_resp = 0;
      job(32'h8000, 16'd3072, 32'h0, 16'd0);
      repeat (20) tick();
      chk("t4_held_count", qa.size(), 8);
      chk("t4_held_valid", cmd_valid, 0);
      resp_budget = 1;
      repeat (3) tick();
      chk("t4_ninth_count", qa.size(), 9);
      chk_cmd("t4_c8", 8, 32'h8800, 16'd256);
      chk("t4_refull_valid", cmd_valid, 0);
      auto_resp = 1; resp_budget = 8;
      wait_done(100, n);
      chk("t4_count", qa.size(), 12);
      chk_cmd("t4_c11", 11, 32'h8B00, 16'd256);
      chk("t4_err", resp_err, 0);

      // zero-length job, then stray response while idle
      qa.delete(); qb.delete();
      job(32'h5000, 16'd0, 32'h0, 16'd3);
      chk("t5_done_low", done, 0);
      chk("t5_valid", cmd_valid, 0);
      tick();
      chk("t5_done_high", done, 1);
      chk("t5_no_cmds", qa.size(), 0);
      resp_budget = 1;
      tick();
      chk("t5_err_set", resp_err, 1);
      chk("t5_done_kept", done, 1);
      job(32'h5000, 16'd0, 32'h0, 16'd0);
      chk("t5_err_clr", resp_err, 0);
      tick();

      // reset with 3 outstanding, then a fresh job
      qa.delete(); qb.delete();
      auto_resp = 0; resp_budget = 0;
      job(32'h9000, 16'd2560, 32'h0, 16'd0);
      repeat (3) tick();
      chk("t6_pre_count", qa.size(), 3);
      chk("t6_pre_done", done, 0);
      rdy = 0; rst = 1;
      tick();
      rst = 0;
      chk("t6_rst_done", done, 1);
      chk("t6_rst_valid", cmd_valid, 0);
      chk("t6_rst_addr", cmd_addr, 0);
      qa.delete(); qb.delete();
      auto_resp = 1; rdy = 1;
      job(32'hA000, 16'd256, 32'h100, 16'd1);
      wait_done(50, n);
      chk("t6_latency", n, 4);
      chk("t6_count", qa.size(), 2);
      chk_cmd("t6_c0", 0, 32'hA000, 16'd256);
      chk_cmd("t6_c1", 1, 32'hA100, 16'd256);
      chk("t6_err", resp_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
